pc_redirect_ctrl: RTL and testbench
===================================

// Module: pc_redirect_ctrl
// PURPOSE
//   Owns the fetch PC register and generates the 3-bit PC-source select consumed by the PC 5:1 mux.
//   Resolves beq/bne/j/jal/jr/jalr in the ID stage and waits (stall request) when branch/jr operands
//   are not yet forwardable. After a taken redirect it squashes the wrong-path instruction in ID.
//   Sits between the decoder/forwarding unit and the IF stage of the pipelined CPU.
// PARAMETERS
//   DATABIT   32            datapath / PC width
//   RESET_PC  32'h0000_3000 PC value loaded on reset
// PORTS
//   Clk          in   1        clock, rising edge
//   Reset_n      in   1        asynchronous, active-low reset
//   Stall        in   1        global freeze from hazard unit; PC and FSM hold
//   IdValid      in   1        ID-stage instruction is valid (not a bubble)
//   BrType       in   3        000 none, 001 beq, 010 j/jal, 011 jr/jalr, 100 bne (others = none)
//   RsReady      in   1        RsData/RtData are final (forwarding resolved)
//   RsData       in   DATABIT  forwarded rs value
//   RtData       in   DATABIT  forwarded rt value
//   BrOffset     in   DATABIT  sign-extended imm16 of branch
//   JIndex       in   26       j/jal instr_index
//   IdPc4        in   DATABIT  PC+4 of the ID-stage instruction
//   Pc           out  DATABIT  current fetch PC (registered)
//   PcSel        out  3        PC-mux select, same encoding as BrType; 000 = PC+4
//   Flush        out  1        ID instruction is wrong-path, treat as NOP (registered)
//   StallReq     out  1        request hazard unit to stall IF/ID (combinational, from FSM state/inputs)
//   RedirectCnt  out  32       taken-redirect count (only with REDIRECT_CNT_EN)
// BEHAVIOUR
//   Reset (async, Reset_n=0): Pc=RESET_PC, state=RUN, Flush=0, StallReq=0, PcSel=000, RedirectCnt=0.
//   Reset mid-stall/mid-flush: abandon immediately, same values; no redirect survives reset.
//   FSM states: RUN, WAIT_OPND, FLUSH.
//   - RUN, no branch (IdValid=0 or BrType none): PcSel=000, Pc<=Pc+4 (mod 2^DATABIT).
//   - RUN, beq/bne/jr with RsReady=0: StallReq=1, PcSel=000, Pc holds, ->WAIT_OPND.
//   - RUN/WAIT_OPND, branch resolvable (j/jal always; others need RsReady=1):
//       taken: beq Rs==Rt, bne Rs!=Rt, j/jr always. Taken -> PcSel=BrType, Pc<=target, ->FLUSH.
//       not taken -> PcSel=000, Pc<=Pc+4, ->RUN.
//   - WAIT_OPND with RsReady=0: StallReq=1, Pc holds, stay.
//   - FLUSH: Flush=1 for exactly one cycle, ID contents ignored (no branch decode), Pc<=Pc+4, ->RUN.
//   Targets: beq/bne IdPc4+(BrOffset<<2), wrap mod 2^DATABIT; j {IdPc4[31:28],JIndex,2'b00};
//     jr {RsData[DATABIT-1:2],2'b00} (low bits forced zero).
//   Stall=1 has priority over everything: Pc, state, Flush, counter hold; PcSel=000; StallReq
//     still reflects WAIT_OPND. A branch pending under Stall resolves on the first unstalled cycle.
//   Latency: redirect decision combinational in ID; Pc updates at next edge; Flush one cycle later.
//   Back-to-back branches: a branch in ID during FLUSH is wrong-path and never redirects.
// CONFIGURATION
//   REDIRECT_CNT_EN defined: RedirectCnt increments (wrapping at 2^32) on each edge committing a taken
//     redirect; holds under Stall. Undefined: port absent, no counter logic.
// STRUCTURE
//   Shared package/header pc_ctrl_pkg: BrType codes (BR_NONE..BR_BNE), FSM state encodings, RESET_PC.
//   Sub-module branch_resolve: combinational compare + target compute (taken, target); FSM, PC
//   register and counter stay in pc_redirect_ctrl.
// TESTING
//   Reset_n low mid-run -> Pc=32'h0000_3000, Flush=0, StallReq=0 immediately, asynchronously.
//   beq Rs=Rt=5, IdPc4=0x3010, BrOffset=-2, RsReady=1 -> PcSel=001, next Pc=0x3008, Flush=1 one cycle.
//   bne Rs=Rt=7 -> PcSel=000, Pc=Pc+4, no Flush; bne Rs=7,Rt=8 -> PcSel=100, taken.
//   jr RsData=0x3043, RsReady=0 for 2 cycles -> StallReq=1, Pc held 2 cycles, then Pc=0x3040, PcSel=011.
//   j JIndex=0x0000C10, IdPc4=0x3004 -> Pc=0x0000_3040; next-cycle branch in ID under Flush ignored.
//   Pc=0xFFFF_FFFC no branch -> Pc=0x0000_0000; Stall=1 during taken beq -> no change until released.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// Shared types for the fetch-PC redirect logic: branch-type codes, FSM states, reset PC.
package pc_ctrl_pkg;

  localparam int unsigned    DATABIT_DEF  = 32;
  localparam logic [31:0]    RESET_PC_DEF = 32'h0000_3000;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BEQ  = 3'b001,
    BR_J    = 3'b010,
    BR_JR   = 3'b011,
    BR_BNE  = 3'b100
  } br_type_e;

  typedef enum logic [1:0] {
    StRun      = 2'b00,
    StWaitOpnd = 2'b01,
    StFlush    = 2'b10
  } pc_state_e;

  // Unused encodings collapse to BR_NONE so they never redirect.
  function automatic br_type_e decode_br(input logic [2:0] raw);
    case (raw)
      3'b001:  return BR_BEQ;
      3'b010:  return BR_J;
      3'b011:  return BR_JR;
      3'b100:  return BR_BNE;
      default: return BR_NONE;
    endcase
  endfunction

  function automatic logic needs_rs(input br_type_e br);
    return (br == BR_BEQ) || (br == BR_BNE) || (br == BR_JR);
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// Combinational branch outcome and target computation for the ID-stage instruction.
module branch_resolve
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned DATABIT = 32
) (
  input  br_type_e           br_type_i,
  input  logic [DATABIT-1:0] rs_data_i,
  input  logic [DATABIT-1:0] rt_data_i,
  input  logic [DATABIT-1:0] br_offset_i,
  input  logic [25:0]        j_index_i,
  input  logic [DATABIT-1:0] id_pc4_i,
  output logic               taken_o,
  output logic [DATABIT-1:0] target_o
);

  logic [DATABIT-1:0] br_target;
  logic               rs_eq_rt;

  assign br_target = id_pc4_i + (br_offset_i << 2);
  assign rs_eq_rt  = (rs_data_i == rt_data_i);

  always_comb begin
    taken_o  = 1'b0;
    target_o = id_pc4_i;
    case (br_type_i)
      BR_BEQ: begin
        taken_o  = rs_eq_rt;
        target_o = br_target;
      end
      BR_BNE: begin
        taken_o  = !rs_eq_rt;
        target_o = br_target;
      end
      BR_J: begin
        taken_o  = 1'b1;
        target_o = {id_pc4_i[DATABIT-1:28], j_index_i, 2'b00};
      end
      BR_JR: begin
        taken_o  = 1'b1;
        target_o = {rs_data_i[DATABIT-1:2], 2'b00};
      end
      default: begin
        taken_o  = 1'b0;
        target_o = id_pc4_i;
      end
    endcase
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC register and PC-mux select with ID-stage branch resolution, operand wait and squash.
// Optional taken-redirect counter enabled by defining REDIRECT_CNT_EN.
module pc_redirect_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned        DATABIT  = 32,
  parameter logic [DATABIT-1:0] RESET_PC = 32'h0000_3000
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Stall,
  input  logic               IdValid,
  input  logic [2:0]         BrType,
  input  logic               RsReady,
  input  logic [DATABIT-1:0] RsData,
  input  logic [DATABIT-1:0] RtData,
  input  logic [DATABIT-1:0] BrOffset,
  input  logic [25:0]        JIndex,
  input  logic [DATABIT-1:0] IdPc4,
  output logic [DATABIT-1:0] Pc,
  output logic [2:0]         PcSel,
  output logic               Flush,
  output logic               StallReq
`ifdef REDIRECT_CNT_EN
  ,
  output logic [31:0]        RedirectCnt
`endif
);

  pc_state_e          state_q, state_d;
  logic [DATABIT-1:0] pc_q, pc_d;
  br_type_e           br_type;
  logic               taken;
  logic [DATABIT-1:0] target;
  logic               resolving;
  logic               blocked;
  logic               redirect;

  assign br_type = IdValid ? decode_br(BrType) : BR_NONE;

  branch_resolve #(
    .DATABIT (DATABIT)
  ) u_branch_resolve (
    .br_type_i   (br_type),
    .rs_data_i   (RsData),
    .rt_data_i   (RtData),
    .br_offset_i (BrOffset),
    .j_index_i   (JIndex),
    .id_pc4_i    (IdPc4),
    .taken_o     (taken),
    .target_o    (target)
  );

  // The instruction in ID during FLUSH is wrong-path, so it is never decoded.
  assign resolving = (state_q != StFlush) && (br_type != BR_NONE);
  assign blocked   = resolving && needs_rs(br_type) && !RsReady;
  assign redirect  = resolving && !blocked && taken;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (!Stall) begin
      unique case (state_q)
        StRun, StWaitOpnd: begin
          if (blocked) begin
            state_d = StWaitOpnd;
          end else if (redirect) begin
            state_d = StFlush;
            pc_d    = target;
          end else begin
            state_d = StRun;
            pc_d    = pc_q + DATABIT'(4);
          end
        end
        StFlush: begin
          state_d = StRun;
          pc_d    = pc_q + DATABIT'(4);
        end
        default: begin
          state_d = StRun;
          pc_d    = pc_q;
        end
      endcase
    end
  end

  // Combinational outputs are forced idle while reset is asserted.
  always_comb begin
    PcSel    = 3'b000;
    StallReq = 1'b0;
    if (Reset_n) begin
      StallReq = blocked;
      if (!Stall && redirect) begin
        PcSel = br_type;
      end
    end
  end

  assign Pc    = pc_q;
  assign Flush = (state_q == StFlush);

`ifdef REDIRECT_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!Stall && redirect) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign RedirectCnt = cnt_q;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed scoreboard bench for pc_redirect_ctrl; build with REDIRECT_CNT_EN to cover the counter.
module tb_pc_redirect_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic        Stall = 1'b0;
  logic        IdValid = 1'b0;
  logic [2:0]  BrType = 3'b000;
  logic        RsReady = 1'b0;
  logic [31:0] RsData = '0;
  logic [31:0] RtData = '0;
  logic [31:0] BrOffset = '0;
  logic [25:0] JIndex = '0;
  logic [31:0] IdPc4 = '0;
  logic [31:0] Pc;
  logic [2:0]  PcSel;
  logic        Flush;
  logic        StallReq;
`ifdef REDIRECT_CNT_EN
  logic [31:0] RedirectCnt;
`endif

  pc_redirect_ctrl #(
    .DATABIT  (32),
    .RESET_PC (32'h0000_3000)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Stall       (Stall),
    .IdValid     (IdValid),
    .BrType      (BrType),
    .RsReady     (RsReady),
    .RsData      (RsData),
    .RtData      (RtData),
    .BrOffset    (BrOffset),
    .JIndex      (JIndex),
    .IdPc4       (IdPc4),
    .Pc          (Pc),
    .PcSel       (PcSel),
    .Flush       (Flush),
    .StallReq    (StallReq)
`ifdef REDIRECT_CNT_EN
    ,
    .RedirectCnt (RedirectCnt)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } item_t;

  item_t sb_q[$];
  int    checks   = 0;
  int    failures = 0;

  task automatic push(input string tag, input logic [31:0] v);
    item_t it;
    it.tag = tag;
    it.val = v;
    sb_q.push_back(it);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    item_t it;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $error("FAIL sb_empty observed=%h expected=<queued item>", obs);
    end else begin
      it = sb_q.pop_front();
      assert (obs === it.val) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", it.tag, obs, it.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] bt, input logic rdy,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] off,
                       input logic [25:0] ji, input logic [31:0] pc4);
    IdValid  = v;
    BrType   = bt;
    RsReady  = rdy;
    RsData   = rs;
    RtData   = rt;
    BrOffset = off;
    JIndex   = ji;
    IdPc4    = pc4;
  endtask

  task automatic idle();
    drive(1'b0, 3'b000, 1'b0, '0, '0, '0, '0, '0);
  endtask

  // Combinational outputs for the inputs just driven.
  task automatic exp_comb(input logic [2:0] sel, input logic sreq);
    push("PcSel", {29'b0, sel});
    push("StallReq", {31'b0, sreq});
    #1;
    pop_chk({29'b0, PcSel});
    pop_chk({31'b0, StallReq});
  endtask

  // Registered outputs after the next clock edge.
  task automatic exp_reg(input logic [31:0] pc, input logic fl);
    push("Pc", pc);
    push("Flush", {31'b0, fl});
    tick();
    pop_chk(Pc);
    pop_chk({31'b0, Flush});
  endtask

  initial begin
    // Asynchronous reset assertion
    #1 Reset_n = 1'b0;
    #2;
    push("rst_Pc", 32'h0000_3000);
    push("rst_Flush", 32'd0);
    pop_chk(Pc);
    pop_chk({31'b0, Flush});
    exp_comb(3'b000, 1'b0);
    tick();
    Reset_n = 1'b1;

    // Sequential fetch
    exp_reg(32'h0000_3004, 1'b0);
    exp_reg(32'h0000_3008, 1'b0);

    // beq taken, backward offset; wrong-path beq during FLUSH is ignored
    drive(1'b1, 3'b001, 1'b1, 32'd5, 32'd5, 32'hFFFF_FFFE, '0, 32'h0000_3010);
    exp_comb(3'b001, 1'b0);
    exp_reg(32'h0000_3008, 1'b1);
    exp_comb(3'b000, 1'b0);
    exp_reg(32'h0000_300C, 1'b0);

    // bne not taken, then taken
    drive(1'b1, 3'b100, 1'b1, 32'd7, 32'd7, 32'd4, '0, 32'h0000_3100);
    exp_comb(3'b000, 1'b0);
    exp_reg(32'h0000_3010, 1'b0);
    drive(1'b1, 3'b100, 1'b1, 32'd7, 32'd8, 32'd4, '0, 32'h0000_3100);
    exp_comb(3'b100, 1'b0);
    exp_reg(32'h0000_3110, 1'b1);
    idle();
    exp_reg(32'h0000_3114, 1'b0);

    // jr waits two cycles for its operand
    drive(1'b1, 3'b011, 1'b0, 32'h0000_3043, '0, '0, '0, 32'h0000_3118);
    exp_comb(3'b000, 1'b1);
    exp_reg(32'h0000_3114, 1'b0);
    exp_comb(3'b000, 1'b1);
    exp_reg(32'h0000_3114, 1'b0);
    RsReady = 1'b1;
    exp_comb(3'b011, 1'b0);
    exp_reg(32'h0000_3040, 1'b1);
    idle();
    exp_reg(32'h0000_3044, 1'b0);

    // j, then a taken bne in the shadow is squashed
    drive(1'b1, 3'b010, 1'b0, '0, '0, '0, 26'h0000C10, 32'h0000_3004);
    exp_comb(3'b010, 1'b0);
    exp_reg(32'h0000_3040, 1'b1);
    drive(1'b1, 3'b100, 1'b1, 32'd1, 32'd2, 32'd64, '0, 32'h0000_3044);
    exp_comb(3'b000, 1'b0);
    exp_reg(32'h0000_3044, 1'b0);

    // Global stall freezes a taken beq until released
    drive(1'b1, 3'b001, 1'b1, 32'd1, 32'd1, 32'h10, '0, 32'h0000_3200);
    Stall = 1'b1;
    exp_comb(3'b000, 1'b0);
    exp_reg(32'h0000_3044, 1'b0);
    Stall = 1'b0;
    exp_comb(3'b001, 1'b0);
    exp_reg(32'h0000_3240, 1'b1);
    idle();
    exp_reg(32'h0000_3244, 1'b0);

    // jr with low bits set lands at the top of the space, then PC wraps
    drive(1'b1, 3'b011, 1'b1, 32'hFFFF_FFFF, '0, '0, '0, 32'h0000_3248);
    exp_comb(3'b011, 1'b0);
    exp_reg(32'hFFFF_FFFC, 1'b1);
    idle();
    exp_reg(32'h0000_0000, 1'b0);
    exp_reg(32'h0000_0004, 1'b0);

`ifdef REDIRECT_CNT_EN
    push("RedirectCnt", 32'd6);
    pop_chk(RedirectCnt);
`endif

    // Reset while waiting on an operand
    drive(1'b1, 3'b011, 1'b0, 32'h0000_1000, '0, '0, '0, 32'h0000_0008);
    exp_comb(3'b000, 1'b1);
    exp_reg(32'h0000_0004, 1'b0);
    Reset_n = 1'b0;
    push("rst2_Pc", 32'h0000_3000);
    push("rst2_Flush", 32'd0);
    #1;
    pop_chk(Pc);
    pop_chk({31'b0, Flush});
    exp_comb(3'b000, 1'b0);
`ifdef REDIRECT_CNT_EN
    push("rst2_RedirectCnt", 32'd0);
    pop_chk(RedirectCnt);
`endif
    idle();
    Reset_n = 1'b1;
    exp_reg(32'h0000_3004, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
